// File: rtl/rx_port_arbiter_if.sv
// rtl/rx_port_arbiter_if.sv - rx requester and packet-memory signal bundle for rx_port_arbiter
interface rx_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
) ();
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]                 port_req_i;
  logic [NUM_PORTS-1:0]                 port_grant_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data_i;
  logic [NUM_PORTS-1:0]                 port_valid_i;
  logic [NUM_PORTS-1:0]                 port_eof_i;
  logic [NUM_PORTS-1:0]                 port_error_i;
  logic                                 mem_ready_i;
  logic [DATA_WIDTH-1:0]                mem_data_o;
  logic                                 mem_valid_o;
  logic                                 mem_sof_o;
  logic                                 mem_eof_o;
  logic                                 mem_error_o;
  logic [PORT_W-1:0]                    mem_port_o;

  modport master (
    output port_req_i, port_data_i, port_valid_i, port_eof_i, port_error_i, mem_ready_i,
    input  port_grant_o, mem_data_o, mem_valid_o, mem_sof_o, mem_eof_o, mem_error_o, mem_port_o
  );

  modport slave (
    input  port_req_i, port_data_i, port_valid_i, port_eof_i, port_error_i, mem_ready_i,
    output port_grant_o, mem_data_o, mem_valid_o, mem_sof_o, mem_eof_o, mem_error_o, mem_port_o
  );
endinterface

// File: rtl/rx_port_arbiter.sv
// rtl/rx_port_arbiter.sv - round-robin rx frame arbiter with stall timeout; RX_ARB_STATS_EN adds frame/timeout counters
module rx_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             switch_clk,
  input  logic             switch_rst,
  rx_port_arbiter_if.slave bus
`ifdef RX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0] frame_count_o,
  output logic [31:0]                timeout_count_o
`endif
);
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PORT_W-1:0]  LAST_RST  = PORT_W'(NUM_PORTS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state, state_next;
  logic [PORT_W-1:0]     sel, last_port, pick, idx;
  logic                  found;
  logic [NUM_PORTS-1:0]  grant;
  logic                  eof_hit, stall_hit, timeout_hit;
  logic [STALL_W-1:0]    stall_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, sof_q, eof_q, error_q;
  logic [PORT_W-1:0]     port_q;

  always_ff @(posedge switch_clk) begin
    if (switch_rst) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next  = state;
    found       = 1'b0;
    pick        = '0;
    idx         = '0;
    grant       = '0;
    eof_hit     = 1'b0;
    stall_hit   = 1'b0;
    timeout_hit = 1'b0;
    // Search starts one past the last served port so every requester gets a turn.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_W'((int'(last_port) + i) % NUM_PORTS);
      if (!found && bus.port_req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    case (state)
      IDLE: if (found) state_next = BUSY;
      BUSY: begin
        grant[sel]  = bus.mem_ready_i & ~switch_rst;
        eof_hit     = bus.port_eof_i[sel];
        stall_hit   = bus.mem_ready_i & ~bus.port_valid_i[sel] & ~bus.port_eof_i[sel];
        timeout_hit = stall_hit && (stall_cnt == STALL_MAX);
        if (eof_hit || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      sel       <= '0;
      last_port <= LAST_RST;
      stall_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      error_q   <= 1'b0;
      port_q    <= '0;
    end else begin
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (found) begin
            sel    <= pick;
            port_q <= pick;
            sof_q  <= 1'b1;
          end
        end
        BUSY: begin
          // Data only advances on accepted cycles so a held byte is never replayed.
          valid_q <= bus.port_valid_i[sel] & bus.mem_ready_i;
          if (bus.mem_ready_i) data_q <= bus.port_data_i[sel];
          if (eof_hit) begin
            eof_q     <= 1'b1;
            error_q   <= bus.port_error_i[sel];
            last_port <= sel;
            stall_cnt <= '0;
          end else if (timeout_hit) begin
            eof_q     <= 1'b1;
            error_q   <= 1'b1;
            last_port <= sel;
            stall_cnt <= '0;
          end else if (bus.mem_ready_i && bus.port_valid_i[sel]) begin
            stall_cnt <= '0;
          end else if (stall_hit && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.port_grant_o = grant;
  assign bus.mem_data_o   = data_q;
  assign bus.mem_valid_o  = valid_q;
  assign bus.mem_sof_o    = sof_q;
  assign bus.mem_eof_o    = eof_q;
  assign bus.mem_error_o  = error_q;
  assign bus.mem_port_o   = port_q;

`ifdef RX_ARB_STATS_EN
  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      frame_count_o   <= '0;
      timeout_count_o <= '0;
    end else if (state == BUSY) begin
      if (eof_hit)          frame_count_o[sel] <= frame_count_o[sel] + 32'd1;
      else if (timeout_hit) timeout_count_o    <= timeout_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: doc/rx_port_arbiter.md
RX_PORT_ARBITER -- requirements
Module: rx_port_arbiter

Interface
REQ-001 The block SHALL provide parameter NUM_PORTS, default 4, meaning the number of rx MAC requesters (2..8).
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 8, meaning the frame byte width.
REQ-003 The block SHALL provide parameter TIMEOUT_CYCLES, default 1024, meaning the number of stall cycles before a granted frame is force-terminated.
REQ-004 The block SHALL have ports switch_clk (input, 1, the single clock) and switch_rst (input, 1, reset), where reset is synchronous and active-high.
REQ-005 The block SHALL have port port_req_i (input, NUM_PORTS), meaning port i has a frame ready to send (SOF seen, not yet granted).
REQ-006 The block SHALL have port port_grant_o (output, NUM_PORTS), the per-port read enable, one-hot or zero.
REQ-007 The block SHALL have port port_data_i (input, NUM_PORTS x DATA_WIDTH), the per-port frame byte.
REQ-008 The block SHALL have ports port_valid_i, port_eof_i and port_error_i (input, NUM_PORTS each), the per-port byte-valid, single-cycle EOF pulse and error-at-EOF.
REQ-009 The block SHALL have port mem_ready_i (input, 1), packet memory backpressure, where 1 means accept.
REQ-010 The block SHALL have ports mem_data_o (output, DATA_WIDTH), mem_valid_o (output, 1), mem_sof_o (output, 1), mem_eof_o (output, 1), mem_error_o (output, 1) and mem_port_o (output, clog2(NUM_PORTS)), the muxed frame stream to memory plus the source port ID.

Function
REQ-011 The arbiter SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE with any port_req_i set, the arbiter SHALL select the first requesting port after last_port in round-robin order, latch it as sel, and enter BUSY on the next edge.
REQ-013 In IDLE, mem_sof_o SHALL pulse for 1 cycle coincident with entry to BUSY, with mem_port_o equal to sel.
REQ-014 In BUSY, port_grant_o[sel] SHALL equal mem_ready_i, combinationally, and all other grant bits SHALL be 0.
REQ-015 The frame lock SHALL hold: sel SHALL NOT change in BUSY, and requests from other ports SHALL be ignored until the frame ends.
REQ-016 Data path latency SHALL be 1 cycle: mem_data_o and mem_valid_o SHALL register port_data_i[sel] and (port_valid_i[sel] and mem_ready_i).
REQ-017 The data path SHALL not duplicate bytes under backpressure: when mem_ready_i=0, mem_valid_o SHALL be 0 the next cycle and mem_data_o SHALL hold its value.
REQ-018 On port_eof_i[sel]=1 in BUSY, the arbiter SHALL register mem_eof_o=1 and mem_error_o=port_error_i[sel], set last_port=sel, and return to IDLE.
REQ-019 After an EOF, the arbiter SHALL insert at least 1 IDLE cycle before the next grant.
REQ-020 A stall counter SHALL increment each BUSY cycle with mem_ready_i=1, port_valid_i[sel]=0 and port_eof_i[sel]=0, and SHALL clear on a valid byte.
REQ-021 When the stall counter equals TIMEOUT_CYCLES-1, the arbiter SHALL emit mem_eof_o=1 and mem_error_o=1, set last_port=sel, and go to IDLE.
REQ-022 The stall counter SHALL saturate and SHALL NOT advance while mem_ready_i=0.
REQ-023 If EOF and timeout occur in the same cycle, EOF SHALL win, with mem_error_o=port_error_i[sel].
REQ-024 If a request is dropped in the same cycle it would be selected, the arbiter SHALL still select it. The grant then yields an immediate EOF, or a timeout if none arrives.
REQ-025 Round-robin arithmetic SHALL wrap modulo NUM_PORTS, so that after NUM_PORTS-1 comes 0.
REQ-026 mem_sof_o and mem_eof_o SHALL never both be 1 in the same cycle.

Reset
REQ-027 On switch_rst=1 at a clock edge, the state SHALL become IDLE, sel SHALL be 0, last_port SHALL be NUM_PORTS-1, and the stall counter SHALL be 0.
REQ-028 On switch_rst=1, all mem_* outputs SHALL be 0 and port_grant_o SHALL be 0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame with no EOF emitted. After release, port 0 SHALL be highest priority.

Configuration
REQ-030 Macro RX_ARB_STATS_EN SHALL control the statistics feature. When it is defined, the block SHALL add output frame_count_o (NUM_PORTS x 32) counting EOFs per port and output timeout_count_o (32) counting forced terminations; both SHALL reset to 0 and wrap at 2^32.
REQ-031 When RX_ARB_STATS_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario: port_req_i=4'b0101 after reset -> port 0 is granted, a 64-byte frame passes, EOF is seen; then port 2 is granted after 1 IDLE cycle.
REQ-033 Scenario: all 4 ports request continuously -> grant order is 0,1,2,3,0, and mem_port_o matches each SOF.
REQ-034 Scenario: mem_ready_i toggles 1,0,1,0 during a frame of bytes 0x00..0x3F -> mem_data_o carries exactly 0x00..0x3F in order, with no duplicates and no drops.
REQ-035 Scenario: port 1 is granted then goes silent, with TIMEOUT_CYCLES=16 -> mem_eof_o=1 and mem_error_o=1 occur exactly 16 ready cycles later, and port 2 is granted next.
REQ-036 Scenario: port_error_i[sel]=1 with EOF -> mem_error_o=1 with mem_eof_o; with stats enabled, frame_count_o for that port increments by 1.
REQ-037 Scenario: switch_rst pulsed mid-frame on port 3 -> next cycle all outputs are 0 and the first grant afterward goes to the lowest requesting port.
